rx_lane_merge: RTL and testbench

RX_LANE_MERGE -- requirements
Module: rx_lane_merge

---
 rtl/rx_lane_merge.sv | 124 ++++++++++++
 tb/tb_rx_lane_merge.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_lane_merge.sv
// Two-lane byte assembler feeding per-lane word FIFOs, merged by
// strict round-robin into a single registered 32-bit word stream.
module rx_lane_merge #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [7:0]  lane0_data,
  input  logic        lane0_valid,
  input  logic [7:0]  lane1_data,
  input  logic        lane1_valid,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        error_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PONE = AW'(1);

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } turn_t;

  logic [7:0]    din  [2];
  logic [1:0]    vin;
  logic [1:0]    cnt  [2];
  logic [23:0]   part [2];
  logic [31:0]   word [2];
  logic [31:0]   mem  [2][FIFO_DEPTH];
  logic [AW-1:0] wp   [2];
  logic [AW-1:0] rp   [2];
  logic [AW:0]   occ  [2];
  logic [1:0]    push;
  logic [1:0]    full;
  logic [1:0]    empty;
  logic [1:0]    pop;
  logic [1:0]    acc;
  logic          ovf;
  logic          sel;
  turn_t         turn;
  turn_t         turn_nxt;

  assign din[0] = lane0_data;
  assign din[1] = lane1_data;
  assign vin    = {lane1_valid, lane0_valid};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      word[i]  = {part[i], din[i]};
      push[i]  = vin[i] && (cnt[i] == 2'd3);
      full[i]  = (occ[i] == FULL);
      empty[i] = (occ[i] == '0);
    end
  end

  // Turn FSM: state register
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) turn <= LANE0;
    else        turn <= turn_nxt;
  end

  // Turn FSM: next state, never skips an empty lane
  always_comb begin
    turn_nxt = turn;
    if (pop[sel]) turn_nxt = (turn == LANE0) ? LANE1 : LANE0;
  end

  // Turn FSM: outputs; a full FIFO being popped still accepts its push
  always_comb begin
    sel      = (turn == LANE1);
    pop      = '0;
    pop[sel] = !empty[sel];
    for (int i = 0; i < 2; i++)
      acc[i] = push[i] && (!full[i] || pop[i]);
    ovf = |(push & full & ~pop);
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        cnt[i]  <= '0;
        part[i] <= '0;
        wp[i]   <= '0;
        rp[i]   <= '0;
        occ[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (vin[i]) begin
          cnt[i]  <= cnt[i] + 2'd1;
          part[i] <= push[i] ? '0 : {part[i][15:0], din[i]};
        end
        if (acc[i]) wp[i] <= wp[i] + PONE;
        if (pop[i]) rp[i] <= rp[i] + PONE;
        unique case (1'b1)
          (acc[i] && !pop[i]): occ[i] <= occ[i] + ONE;
          (!acc[i] && pop[i]): occ[i] <= occ[i] - ONE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_4f) begin
    for (int i = 0; i < 2; i++)
      if (acc[i]) mem[i][wp[i]] <= word[i];
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      valid_out <= |pop;
      if (|pop) data_out <= mem[sel][rp[sel]];
      error_out <= error_out | ovf;
    end
  end

endmodule

// File: tb/tb_rx_lane_merge.sv
// Bench for rx_lane_merge: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_rx_lane_merge;

  localparam int DEPTH = 4;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [7:0]  lane0_data, lane1_data;
  logic        lane0_valid, lane1_valid;
  logic [31:0] data_out;
  logic        valid_out, error_out;

  int checks = 0;
  int failures = 0;

  logic [7:0]  bq0[$], bq1[$];
  logic [31:0] mq0[$], mq1[$];
  bit          mturn;
  logic        exp_valid, exp_err;
  logic [31:0] exp_data;

  rx_lane_merge #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_4f(clk_4f), .reset(reset),
    .lane0_data(lane0_data), .lane0_valid(lane0_valid),
    .lane1_data(lane1_data), .lane1_valid(lane1_valid),
    .data_out(data_out), .valid_out(valid_out), .error_out(error_out)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic model_clear();
    bq0.delete(); bq1.delete(); mq0.delete(); mq1.delete();
    mturn = 0; exp_valid = 0; exp_err = 0; exp_data = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk_4f);
    reset = 0;
    lane0_valid = 0; lane1_valid = 0;
    lane0_data = '0; lane1_data = '0;
    model_clear();
    @(negedge clk_4f);
    reset = 1;
  endtask

  // Drive one cycle and advance the reference model; returns #1 after the edge.
  task automatic cycle(input bit v0, input logic [7:0] d0,
                       input bit v1, input logic [7:0] d1);
    bit r0, r1;
    logic [31:0] w0, w1;
    @(negedge clk_4f);
    lane0_valid = v0; lane0_data = d0;
    lane1_valid = v1; lane1_data = d1;
    r0 = 0; r1 = 0; w0 = '0; w1 = '0;
    if (v0) begin
      bq0.push_back(d0);
      if (bq0.size() == 4) begin
        w0 = {bq0[0], bq0[1], bq0[2], bq0[3]}; r0 = 1; bq0.delete();
      end
    end
    if (v1) begin
      bq1.push_back(d1);
      if (bq1.size() == 4) begin
        w1 = {bq1[0], bq1[1], bq1[2], bq1[3]}; r1 = 1; bq1.delete();
      end
    end
    exp_valid = 0;
    if (!mturn && mq0.size() > 0) begin
      exp_data = mq0.pop_front(); exp_valid = 1; mturn = 1;
    end else if (mturn && mq1.size() > 0) begin
      exp_data = mq1.pop_front(); exp_valid = 1; mturn = 0;
    end
    if (r0) begin
      if (mq0.size() < DEPTH) mq0.push_back(w0); else exp_err = 1;
    end
    if (r1) begin
      if (mq1.size() < DEPTH) mq1.push_back(w1); else exp_err = 1;
    end
    @(posedge clk_4f);
    #1;
  endtask

  task automatic test_reset();
    reset = 0;
    lane0_valid = 0; lane1_valid = 0;
    lane0_data = '0; lane1_data = '0;
    model_clear();
    #3;
    checks++;
    if ({valid_out, error_out, data_out} !== 34'h0) begin
      failures++;
      $display("FAIL reset_state got v=%b e=%b d=%h exp 0 0 00000000",
               valid_out, error_out, data_out);
    end
    @(negedge clk_4f);
    reset = 1;
  endtask

  task automatic test_basic();
    logic [7:0] d0, d1;
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      d0 = 8'h11 * 8'(c + 1);
      d1 = 8'hAA + 8'h11 * 8'(c - 4);
      cycle(c < 4, d0, c >= 4 && c < 8, d1);
      checks++;
      if ({valid_out, error_out, data_out} !== {exp_valid, exp_err, exp_data}) begin
        failures++;
        $display("FAIL basic c%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                 c, valid_out, error_out, data_out, exp_valid, exp_err, exp_data);
      end
      if (c == 4 || c == 8) begin
        checks++;
        if (!valid_out || data_out !== (c == 4 ? 32'h11223344 : 32'hAABBCCDD)) begin
          failures++;
          $display("FAIL basic_word c%0d got v=%b d=%h", c, valid_out, data_out);
        end
      end
    end
  endtask

  task automatic test_order();
    logic [7:0] d0, d1;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      d1 = 8'hAA + 8'h11 * 8'(c);
      d0 = 8'h11 * 8'(c - 3);
      cycle(c >= 4 && c < 8, d0, c < 4, d1);
      checks++;
      if ({valid_out, error_out, data_out} !== {exp_valid, exp_err, exp_data}) begin
        failures++;
        $display("FAIL order c%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                 c, valid_out, error_out, data_out, exp_valid, exp_err, exp_data);
      end
      if (c == 8 || c == 9) begin
        checks++;
        if (!valid_out || data_out !== (c == 8 ? 32'h11223344 : 32'hAABBCCDD)) begin
          failures++;
          $display("FAIL order_word c%0d got v=%b d=%h", c, valid_out, data_out);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] tbl [7];
    bit         vt  [7];
    tbl = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h04};
    vt  = '{1, 1, 0, 0, 0, 1, 1};
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      cycle(c < 7 ? vt[c] : 1'b0, c < 7 ? tbl[c] : 8'h00, 1'b0, 8'h00);
      checks++;
      if ({valid_out, error_out, data_out} !== {exp_valid, exp_err, exp_data}) begin
        failures++;
        $display("FAIL gaps c%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                 c, valid_out, error_out, data_out, exp_valid, exp_err, exp_data);
      end
      checks++;
      if (valid_out !== (c == 7) || (c == 7 && data_out !== 32'h01020304)) begin
        failures++;
        $display("FAIL gaps_word c%0d got v=%b d=%h exp v=%b d=01020304",
                 c, valid_out, data_out, c == 7);
      end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      cycle(1'b1, 8'($urandom), 1'b0, 8'h00);
      checks++;
      if ({valid_out, error_out, data_out} !== {exp_valid, exp_err, exp_data}) begin
        failures++;
        $display("FAIL overflow c%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                 c, valid_out, error_out, data_out, exp_valid, exp_err, exp_data);
      end
    end
    checks++;
    if (error_out !== 1'b1) begin
      failures++;
      $display("FAIL overflow_err got %b exp 1", error_out);
    end
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 8'h00, c < 4, 8'($urandom));
      checks++;
      if ({valid_out, error_out, data_out} !== {exp_valid, exp_err, exp_data}) begin
        failures++;
        $display("FAIL overflow_rel c%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                 c, valid_out, error_out, data_out, exp_valid, exp_err, exp_data);
      end
    end
    checks++;
    if (error_out !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky got %b exp 1", error_out);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] b6 [4];
    logic [31:0] w6;
    bit seen;
    apply_reset();
    for (int i = 0; i < 4; i++) b6[i] = 8'($urandom);
    w6 = {b6[0], b6[1], b6[2], b6[3]};
    seen = 0;
    for (int c = 0; c < 20; c++) cycle(1'b1, 8'($urandom), 1'b0, 8'h00);
    for (int c = 0; c < 6; c++) begin
      cycle(c >= 2, c >= 2 ? b6[c-2] : 8'h00, c < 4, 8'($urandom));
      checks++;
      if ({valid_out, error_out, data_out} !== {exp_valid, exp_err, exp_data}) begin
        failures++;
        $display("FAIL full_pop c%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                 c, valid_out, error_out, data_out, exp_valid, exp_err, exp_data);
      end
    end
    checks++;
    if (error_out !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_err got %b exp 0", error_out);
    end
    for (int c = 0; c < 24; c++) begin
      cycle(1'b0, 8'h00, c < 16, 8'($urandom));
      if (valid_out && data_out === w6) seen = 1;
      checks++;
      if ({valid_out, error_out, data_out} !== {exp_valid, exp_err, exp_data}) begin
        failures++;
        $display("FAIL full_pop_drain c%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                 c, valid_out, error_out, data_out, exp_valid, exp_err, exp_data);
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL full_pop_word got missing exp %h", w6);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pre [10];
    pre = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h9A, 8'h9B, 8'h9C, 8'h11, 8'h22};
    apply_reset();
    for (int c = 0; c < 10; c++) cycle(1'b1, pre[c], 1'b0, 8'h00);
    #2;
    reset = 0;
    #1;
    checks++;
    if ({valid_out, error_out, data_out} !== 34'h0) begin
      failures++;
      $display("FAIL reset_mid got v=%b e=%b d=%h exp 0 0 00000000",
               valid_out, error_out, data_out);
    end
    model_clear();
    lane0_valid = 0;
    @(negedge clk_4f);
    reset = 1;
    for (int c = 0; c < 8; c++) begin
      cycle(c < 2, c == 0 ? 8'h33 : 8'h44, 1'b0, 8'h00);
      checks++;
      if (valid_out !== 1'b0 || data_out !== exp_data || error_out !== exp_err) begin
        failures++;
        $display("FAIL reset_after c%0d got v=%b e=%b d=%h exp v=0 e=%b d=%h",
                 c, valid_out, error_out, data_out, exp_err, exp_data);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom),
            $urandom_range(0, 2) == 0, 8'($urandom));
      checks++;
      if ({valid_out, error_out, data_out} !== {exp_valid, exp_err, exp_data}) begin
        failures++;
        $display("FAIL random c%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                 c, valid_out, error_out, data_out, exp_valid, exp_err, exp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_gaps();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
